// File: rtl/data_memory.sv
// Byte/halfword/word data memory: combinational loads, stores commit at the clock edge.
// Illegal accesses are suppressed; the first one since the last clear is held in a sticky record.
module data_memory #(
  parameter int N     = 32,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   size,
  input  logic         load_unsigned,
  input  logic         err_clr,
  output logic [N-1:0] rdata,
  output logic         misaligned,
  output logic         fault,
  output logic [N-1:0] fault_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  mem_q [DEPTH];
  logic          fault_q;
  logic [N-1:0]  fault_addr_q;

  logic [AW-1:0] word_idx;
  logic [N-1:0]  word_rd;
  logic          access;
  logic          align_err;
  logic          out_of_range;
  logic          size_bad;
  logic          illegal;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [4:0]    byte_sh;
  logic [4:0]    half_sh;
  logic [N-1:0]  wr_mask;
  logic [N-1:0]  wr_val;

  assign word_idx     = addr[2 +: AW];
  assign word_rd      = mem_q[word_idx];
  assign access       = mem_read | mem_write;
  assign out_of_range = |addr[N-1:AW+2];
  assign size_bad     = (size == 2'b11);
  assign byte_sh      = {addr[1:0], 3'b000};
  assign half_sh      = {addr[1], 4'b0000};

  always_comb begin
    align_err = 1'b0;
    case (size)
      2'b01:   align_err = addr[0];
      2'b10:   align_err = |addr[1:0];
      default: align_err = 1'b0;
    endcase
  end

  assign misaligned = access & align_err;
  assign illegal    = access & (align_err | out_of_range | size_bad);

  assign byte_sel = 8'(word_rd >> byte_sh);
  assign half_sel = 16'(word_rd >> half_sh);

  always_comb begin
    rdata = '0;
    if (mem_read && !illegal) begin
      case (size)
        2'b00:   rdata = {{(N-8){byte_sel[7] & ~load_unsigned}}, byte_sel};
        2'b01:   rdata = {{(N-16){half_sel[15] & ~load_unsigned}}, half_sel};
        default: rdata = word_rd;
      endcase
    end
  end

  // Lane mask and data positioned at the addressed byte/halfword within the word.
  always_comb begin
    wr_mask = '0;
    wr_val  = '0;
    case (size)
      2'b00: begin
        wr_mask = N'(8'hFF) << byte_sh;
        wr_val  = N'(wdata[7:0]) << byte_sh;
      end
      2'b01: begin
        wr_mask = N'(16'hFFFF) << half_sh;
        wr_val  = N'(wdata[15:0]) << half_sh;
      end
      default: begin
        wr_mask = '1;
        wr_val  = wdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_write && !illegal) begin
      mem_q[word_idx] <= (word_rd & ~wr_mask) | (wr_val & wr_mask);
    end
  end

  // A clear coinciding with a new fault restarts the record at the new address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else if (illegal) begin
      fault_q <= 1'b1;
      if (!fault_q || err_clr) begin
        fault_addr_q <= addr;
      end
    end else if (err_clr) begin
      fault_q <= 1'b0;
    end
  end

  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed vector bench for data_memory: table of accesses with hand-computed results.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic        mem_read, mem_write, load_unsigned, err_clr;
  logic [1:0]  size;
  logic [31:0] rdata, fault_addr;
  logic        misaligned, fault;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        lu;
    logic        clr;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_fault;
    logic [31:0] exp_faddr;
  } vec_t;

  vec_t vt[$];

  data_memory #(.N(32), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .load_unsigned(load_unsigned), .err_clr(err_clr),
    .rdata(rdata), .misaligned(misaligned), .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [31:0] a, input logic [31:0] wd,
                     input logic rd, input logic wr, input logic [1:0] sz, input logic lu,
                     input logic clr, input logic [31:0] er, input logic em,
                     input logic ef, input logic [31:0] efa);
    vec_t v;
    v.name = name; v.addr = a; v.wdata = wd; v.rd = rd; v.wr = wr; v.size = sz;
    v.lu = lu; v.clr = clr; v.exp_rdata = er; v.exp_mis = em; v.exp_fault = ef;
    v.exp_faddr = efa;
    vt.push_back(v);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic lu, input logic clr);
    addr = a; wdata = wd; mem_read = rd; mem_write = wr; size = sz;
    load_unsigned = lu; err_clr = clr;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);

    // name, addr, wdata, rd, wr, size, lu, clr, exp rdata, exp mis, fault/fault_addr before edge
    add("lw_0x00",     32'h000, 32'h0,        1, 0, 2'b10, 0, 0, 32'h0,        0, 0, 32'h0);
    add("lw_0x04",     32'h004, 32'h0,        1, 0, 2'b10, 0, 0, 32'h0,        0, 0, 32'h0);
    add("lw_0xfc",     32'h0FC, 32'h0,        1, 0, 2'b10, 0, 0, 32'h0,        0, 0, 32'h0);
    add("sw_0x10",     32'h010, 32'hDEADBEEF, 0, 1, 2'b10, 0, 0, 32'h0,        0, 0, 32'h0);
    add("lw_0x10",     32'h010, 32'h0,        1, 0, 2'b10, 0, 0, 32'hDEADBEEF, 0, 0, 32'h0);
    add("lw_0x14",     32'h014, 32'h0,        1, 0, 2'b10, 0, 0, 32'h0,        0, 0, 32'h0);
    add("sb_0x11",     32'h011, 32'hAAAAAA7F, 0, 1, 2'b00, 0, 0, 32'h0,        0, 0, 32'h0);
    add("lw_after_sb", 32'h010, 32'h0,        1, 0, 2'b10, 0, 0, 32'hDEAD7FEF, 0, 0, 32'h0);
    add("lb_0x13",     32'h013, 32'h0,        1, 0, 2'b00, 0, 0, 32'hFFFFFFDE, 0, 0, 32'h0);
    add("lbu_0x13",    32'h013, 32'h0,        1, 0, 2'b00, 1, 0, 32'h000000DE, 0, 0, 32'h0);
    add("sh_0x12",     32'h012, 32'h55558001, 0, 1, 2'b01, 0, 0, 32'h0,        0, 0, 32'h0);
    add("lh_0x12",     32'h012, 32'h0,        1, 0, 2'b01, 0, 0, 32'hFFFF8001, 0, 0, 32'h0);
    add("lhu_0x12",    32'h012, 32'h0,        1, 0, 2'b01, 1, 0, 32'h00008001, 0, 0, 32'h0);
    add("lw_after_sh", 32'h010, 32'h0,        1, 0, 2'b10, 0, 0, 32'h80017FEF, 0, 0, 32'h0);
    add("lb_0x10",     32'h010, 32'h0,        1, 0, 2'b00, 0, 0, 32'hFFFFFFEF, 0, 0, 32'h0);
    add("lb_0x11_pos", 32'h011, 32'h0,        1, 0, 2'b00, 0, 0, 32'h0000007F, 0, 0, 32'h0);
    add("lh_0x10_pos", 32'h010, 32'h0,        1, 0, 2'b01, 0, 0, 32'h00007FEF, 0, 0, 32'h0);
    add("sw_mis_0x22", 32'h022, 32'h12345678, 0, 1, 2'b10, 0, 0, 32'h0,        1, 0, 32'h0);
    add("lw_0x20",     32'h020, 32'h0,        1, 0, 2'b10, 0, 0, 32'h0,        0, 1, 32'h22);
    add("lh_mis_0x31", 32'h031, 32'h0,        1, 0, 2'b01, 0, 0, 32'h0,        1, 1, 32'h22);
    add("hold_first",  32'h030, 32'h0,        1, 0, 2'b10, 0, 0, 32'h0,        0, 1, 32'h22);
    add("clr_1",       32'h000, 32'h0,        0, 0, 2'b10, 0, 1, 32'h0,        0, 1, 32'h22);
    add("lw_oor_0x100",32'h100, 32'h0,        1, 0, 2'b10, 0, 0, 32'h0,        0, 0, 32'h22);
    add("oor_fault",   32'h000, 32'h0,        0, 0, 2'b10, 0, 0, 32'h0,        0, 1, 32'h100);
    add("clr_2",       32'h000, 32'h0,        0, 0, 2'b10, 0, 1, 32'h0,        0, 1, 32'h100);
    add("clr_and_sw",  32'h101, 32'h0BADF00D, 0, 1, 2'b10, 0, 1, 32'h0,        1, 0, 32'h100);
    add("collide_res", 32'h000, 32'h0,        0, 0, 2'b10, 0, 0, 32'h0,        0, 1, 32'h101);
    add("size11_rd",   32'h040, 32'h0,        1, 0, 2'b11, 0, 0, 32'h0,        0, 1, 32'h101);
    add("sb_oor_0x110",32'h110, 32'h000000FF, 0, 1, 2'b00, 0, 0, 32'h0,        0, 1, 32'h101);
    add("oor_no_alias",32'h010, 32'h0,        1, 0, 2'b10, 0, 0, 32'h80017FEF, 0, 1, 32'h101);
    add("clr_3",       32'h000, 32'h0,        0, 0, 2'b10, 0, 1, 32'h0,        0, 1, 32'h101);
    add("sw_0x40",     32'h040, 32'h11111111, 0, 1, 2'b10, 0, 0, 32'h0,        0, 0, 32'h101);
    add("rw_0x40_pre", 32'h040, 32'h22222222, 1, 1, 2'b10, 0, 0, 32'h11111111, 0, 0, 32'h101);

    repeat (2) @(negedge clk);
    #1;
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_faddr", fault_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].addr, vt[i].wdata, vt[i].rd, vt[i].wr, vt[i].size, vt[i].lu, vt[i].clr);
      #1;
      check({vt[i].name, ".rdata"}, rdata, vt[i].exp_rdata);
      check({vt[i].name, ".mis"},   32'(misaligned), 32'(vt[i].exp_mis));
      check({vt[i].name, ".fault"}, 32'(fault), 32'(vt[i].exp_fault));
      check({vt[i].name, ".faddr"}, fault_addr, vt[i].exp_faddr);
    end

    // Read-before-write collision: the edge after the last vector commits 0x22222222.
    @(posedge clk);
    #1;
    check("rw_0x40_post", rdata, 32'h22222222);

    // Reset mid-cycle while a store is pending clears memory at once and drops the store.
    drive(32'h044, 32'h33333333, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_rdata", rdata, 32'h0);
    check("rst_async_fault", 32'(fault), 32'h0);
    check("rst_async_faddr", fault_addr, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h044, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    #1;
    check("store_in_reset_lost", rdata, 32'h0);
    drive(32'h040, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    #1;
    check("rst_cleared_0x40", rdata, 32'h0);

    // First store after release commits on the first rising edge.
    drive(32'h048, 32'hCAFEF00D, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(32'h048, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    #1;
    check("first_store_after_rst", rdata, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
